// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode values, opcode width
// and the controller state encoding.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
    localparam logic [OP_W-1:0] OP_PASS = 4'd6;
    localparam logic [OP_W-1:0] OP_ADC  = 4'd7;
    localparam logic [OP_W-1:0] OP_SBB  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd9;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd10;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: arithmetic, logic and pass operations with flags.
// Shift opcodes land here only for a zero count, so they simply pass a through.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cy,
    output logic             zf,
    output logic             nf,
    output logic             ov
);

    logic             carry_add;
    logic             borrow_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Extra top bit of sum/diff is the carry out or the borrow.
    always_comb begin
        carry_add = (op == OP_ADC) ? cin : 1'b0;
        borrow_in = (op == OP_SBB) ? cin : 1'b0;
        sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_add};
        diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, borrow_in};

        result = b;
        cy     = 1'b0;
        ov     = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                result = sum[WIDTH-1:0];
                cy     = sum[WIDTH];
                ov     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                result = diff[WIDTH-1:0];
                cy     = diff[WIDTH];
                ov     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_XOR:         result = a ^ b;
            OP_NOT:         result = ~a;
            OP_PASS:        result = b;
            OP_SHL, OP_SHR: result = a;
            default:        result = b;
        endcase

        zf = (result == '0);
        nf = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete in one edge, shifts move one bit
// per cycle and multiply is shift-add with one partial product per cycle.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cy,
    output logic             zf,
    output logic             nf,
    output logic             ov
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    state_t             state;
    state_t             state_next;

    logic [OP_W-1:0]    op_q;
    logic [WIDTH-1:0]   shreg;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      count;

    logic [SW-1:0]      shift_n;
    logic               is_shift;
    logic               is_mul;
    logic               multi;
    logic               last_step;
    logic [WIDTH-1:0]   shift_val;
    logic               shift_out;
    logic [2*WIDTH-1:0] prod_step;

    logic [WIDTH-1:0]   comb_result;
    logic               comb_cy;
    logic               comb_zf;
    logic               comb_nf;
    logic               comb_ov;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .result (comb_result),
        .cy     (comb_cy),
        .zf     (comb_zf),
        .nf     (comb_nf),
        .ov     (comb_ov)
    );

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // A zero shift count is handled like any single-cycle op.
    always_comb begin
        shift_n   = b[SW-1:0];
        is_shift  = (op == OP_SHL) || (op == OP_SHR);
        is_mul    = (op == OP_MUL);
        multi     = is_mul || (is_shift && (shift_n != '0));
        last_step = (count == CW'(1));

        if (op_q == OP_SHL) begin
            shift_val = {shreg[WIDTH-2:0], 1'b0};
            shift_out = shreg[WIDTH-1];
        end else begin
            shift_val = {1'b0, shreg[WIDTH-1:1]};
            shift_out = shreg[0];
        end
        prod_step = prod + (shreg[0] ? mcand : '0);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = multi ? ST_RUN : ST_DONE;
            ST_RUN:  if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Visible result and flags are written only at acceptance of a
    // single-cycle op or on the final RUN step, so they hold during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            shreg  <= '0;
            mcand  <= '0;
            prod   <= '0;
            count  <= '0;
            result <= '0;
            cy     <= 1'b0;
            zf     <= 1'b0;
            nf     <= 1'b0;
            ov     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        if (multi) begin
                            count <= is_mul ? CW'(WIDTH) : CW'(shift_n);
                            shreg <= is_mul ? b : a;
                            mcand <= {{WIDTH{1'b0}}, a};
                            prod  <= '0;
                        end else begin
                            result <= comb_result;
                            cy     <= comb_cy;
                            zf     <= comb_zf;
                            nf     <= comb_nf;
                            ov     <= comb_ov;
                        end
                    end
                end
                ST_RUN: begin
                    count <= count - CW'(1);
                    if (op_q == OP_MUL) begin
                        prod  <= prod_step;
                        mcand <= mcand << 1;
                        shreg <= shreg >> 1;
                        if (last_step) begin
                            result <= prod_step[WIDTH-1:0];
                            cy     <= |prod_step[2*WIDTH-1:WIDTH];
                            zf     <= (prod_step[WIDTH-1:0] == '0);
                            nf     <= prod_step[WIDTH-1];
                            ov     <= 1'b0;
                        end
                    end else begin
                        shreg <= shift_val;
                        if (last_step) begin
                            result <= shift_val;
                            cy     <= shift_out;
                            zf     <= (shift_val == '0);
                            nf     <= shift_val[WIDTH-1];
                            ov     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized checks of alu_mc (WIDTH=8) against an integer
// reference model of each opcode, its flags and its latency.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cy;
    logic         zf;
    logic         nf;
    logic         ov;

    int checks = 0;
    int passes = 0;
    int exp_prev_result = 0;

    alu_mc #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cy     (cy),
        .zf     (zf),
        .nf     (nf),
        .ov     (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) passes = passes + 1;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic int to_signed(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Expected behaviour from plain integer arithmetic.
    function automatic void model(input int o, input int x, input int y, input int c,
                                  output int r, output int fc, output int fz,
                                  output int fn, output int fv, output int lat);
        int s;
        int n;
        n   = y % W;
        fc  = 0;
        fv  = 0;
        lat = 1;
        case (o)
            0, 7: begin
                s  = x + y + ((o == 7) ? c : 0);
                r  = s % 256;
                fc = (s > 255) ? 1 : 0;
                s  = to_signed(x) + to_signed(y) + ((o == 7) ? c : 0);
                fv = (s > 127 || s < -128) ? 1 : 0;
            end
            1, 8: begin
                s  = x - y - ((o == 8) ? c : 0);
                r  = (s + 512) % 256;
                fc = (s < 0) ? 1 : 0;
                s  = to_signed(x) - to_signed(y) - ((o == 8) ? c : 0);
                fv = (s > 127 || s < -128) ? 1 : 0;
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 255 - x;
            9: begin
                r   = (x << n) % 256;
                fc  = (n == 0) ? 0 : (x >> (W - n)) & 1;
                lat = n + 1;
            end
            10: begin
                r   = x >> n;
                fc  = (n == 0) ? 0 : (x >> (n - 1)) & 1;
                lat = n + 1;
            end
            11: begin
                s   = x * y;
                r   = s % 256;
                fc  = (s > 255) ? 1 : 0;
                lat = W + 1;
            end
            default: r = y;
        endcase
        fz = (r == 0) ? 1 : 0;
        fn = (r >> (W - 1)) & 1;
    endfunction

    // Called just after an edge with the DUT idle; returns just after the
    // edge that follows done. poke_cycle pulses a competing ADD request in
    // that RUN cycle; poke_done raises start in the DONE cycle.
    task automatic apply_stimulus(input int o, input int x, input int y, input int c,
                                  input int poke_cycle, input bit poke_done, input string tag);
        int er, ec, ez, en, ev, lat, cyc;
        bit hold_ok;
        model(o, x, y, c, er, ec, ez, en, ev, lat);
        op    = 4'(o);
        a     = 8'(x);
        b     = 8'(y);
        cin   = 1'(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        cyc     = 1;
        hold_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (result !== 8'(exp_prev_result) || busy !== 1'b1) hold_ok = 1'b0;
            if (cyc == poke_cycle) begin
                start = 1'b1;
                op    = 4'd0;
                a     = 8'd1;
                b     = 8'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc   = cyc + 1;
        end
        check_output({tag, " latency"}, cyc, lat);
        check_output({tag, " result"}, result, er);
        check_output({tag, " cy"}, cy, ec);
        check_output({tag, " zf"}, zf, ez);
        check_output({tag, " nf"}, nf, en);
        check_output({tag, " ov"}, ov, ev);
        check_output({tag, " busy_in_done"}, busy, 1);
        check_output({tag, " hold_during_run"}, hold_ok, 1);
        exp_prev_result = er;
        if (poke_done) begin
            start = 1'b1;
            op    = 4'd0;
            a     = 8'd1;
            b     = 8'd1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output({tag, " done_pulse"}, done, 0);
        check_output({tag, " idle_after"}, busy, 0);
        check_output({tag, " result_kept"}, result, er);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #12;
        check_output("reset busy", busy, 0);
        check_output("reset done", done, 0);
        check_output("reset result", result, 0);
        check_output("reset cy", cy, 0);
        check_output("reset zf", zf, 0);
        check_output("reset nf", nf, 0);
        check_output("reset ov", ov, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(0,  'hFF, 'h01, 0, 0, 0, "add_ff_01");
        apply_stimulus(1,  'h80, 'h01, 0, 0, 0, "sub_80_01");
        apply_stimulus(9,  'hA0, 3,    0, 0, 0, "shl_a0_3");
        apply_stimulus(11, 'h10, 'h10, 0, 3, 0, "mul_poke");
        apply_stimulus(7,  'h7F, 'h00, 1, 0, 0, "adc_7f_cin");
        apply_stimulus(10, 'h5A, 0,    0, 0, 1, "shr_zero");
        apply_stimulus(8,  'h00, 'hFF, 1, 0, 0, "sbb_borrow");
        apply_stimulus(10, 'hC3, 7,    0, 2, 0, "shr_c3_7");
        apply_stimulus(13, 'h11, 'h22, 1, 0, 0, "pass_alias");

        // Abort a multiply by reset, then confirm immediate restart.
        op    = 4'd11;
        a     = 8'h33;
        b     = 8'h44;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort busy", busy, 0);
        check_output("abort done", done, 0);
        check_output("abort result", result, 0);
        check_output("abort cy", cy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_prev_result = 0;
        @(posedge clk);
        #1;
        apply_stimulus(0, 3, 4, 0, 0, 0, "add_after_reset");

        for (int i = 0; i < 40; i++) begin
            int ro, rx, ry, rc, rp;
            bit rd;
            ro = int'($urandom_range(0, 15));
            rx = int'($urandom_range(0, 255));
            ry = int'($urandom_range(0, 255));
            rc = int'($urandom_range(0, 1));
            rp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            rd = 1'($urandom_range(0, 1));
            apply_stimulus(ro, rx, ry, rc, rp, rd, $sformatf("rnd%0d_op%0d", i, ro));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
